approx_rc_adder_pipe: RTL and testbench
=======================================

# approx_rc_adder_pipe

Parametrised, pipelined ripple-carry adder whose APPROX_BITS least-significant positions use the approximate full-adder cell (S = X|Y, Cout = X&Y, carry-in ignored), with the remaining positions exact. Approximation is runtime-selectable per operation. Operands enter through a valid/ready handshake, and results leave through a valid/ready handshake after a fixed pipeline latency. It is the drop-in successor of the fixed 8-bit combinational approximate ripple adders for the power/MAE evaluation flow, and can optionally carry an on-line error monitor.

## Interface
- WIDTH, 8: operand width; result is WIDTH+1 bits
- APPROX_BITS, 4: number of LSB positions using the approximate cell; range 0..WIDTH
- STAGE_BITS, 4: bit positions resolved per pipeline stage; STAGES = ceil(WIDTH/STAGE_BITS)
- ACC_W, 32: error accumulator width (monitor only)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- approx_en  in  1  1 = approximate LSBs, 0 = fully exact; sampled with operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH+1  sum, MSB is carry-out
- err_clr  in  1  synchronous clear of monitor statistics (monitor only)
- err_abs  out  WIDTH+1  |exact − out_sum| for current result (monitor only)
- err_sum  out  ACC_W  saturating sum of err_abs over accepted results (monitor only)
- err_max  out  WIDTH+1  maximum err_abs seen (monitor only)
- err_cnt  out  ACC_W  accepted results counted, saturating (monitor only)

## Operation
- Bit i with i < APPROX_BITS and approx_en = 1: s_i = a_i|b_i, c_{i+1} = a_i&b_i. Incoming carry is discarded.
- All other bits: exact full adder. Carry into bit 0 is 0.
- With approx_en = 0, the whole adder is exact.
- Stage k resolves bits [k·STAGE_BITS, min((k+1)·STAGE_BITS, WIDTH)−1]. It registers its partial sum bits, its carry-out, the upper operand bits still unconsumed, and approx_en.
- The final stage's carry-out drives out_sum[WIDTH].
- Each stage holds a valid bit. Global advance signal adv = ~out_valid | out_ready.
  - When adv = 1, every stage shifts forward, bubbles included.
  - When adv = 0, all stages hold.
- in_ready = adv. An operand is accepted on a cycle with in_valid & in_ready.
- Handshake rules:
  - out_sum and out_valid stay stable while out_valid & ~out_ready.
  - in_valid may be dropped without acceptance, and no entry is created.
- APPROX_BITS = 0 yields an exact pipelined adder.
- APPROX_BITS = WIDTH makes out_sum[WIDTH] the AND of the operand MSBs.

## Timing
- Latency: an operand accepted in cycle t produces out_valid in cycle t+STAGES, if not stalled.
- Throughput is one result per cycle while out_ready = 1.
- Back-pressure: out_ready = 0 with out_valid = 1 stalls the entire pipeline the same cycle (in_ready = 0 combinationally).
- Reset: all stage valids 0, all data registers 0, out_valid 0, out_sum 0, and all err_* outputs 0.
- Reset mid-operation discards in-flight entries without emitting them.
- Simultaneous err_clr and result acceptance: the clear wins, and statistics become 0 that cycle; the accepted result is not counted.
- Accumulation happens on the output handshake (out_valid & out_ready).
- err_sum and err_cnt saturate at 2^ACC_W−1.

## Configuration
- APPROX_ADDER_ERR_MONITOR_EN defined:
  - an exact reference sum is carried through the pipeline alongside each entry;
  - err_abs, err_sum, err_max and err_cnt are generated as specified;
  - err_clr is honoured.
- Macro undefined:
  - no reference path or statistics registers;
  - err_* outputs tie to 0 and err_clr is ignored;
  - all other behaviour is identical.

## Structure
- Package approx_adder_pkg:
  - function approx_fa(x, y, z) returning {cout, s};
  - exact full-adder function;
  - stage-count helper function ceil_div.
- Sub-module approx_rc_stage: one combinational+registered slice with parameters LO, HI and APPROX_BITS, instantiated STAGES times via generate.
- The top level holds the handshake and the error monitor.

## Test plan
Default parameters unless stated.
- Reset: hold rst_n low, drive in_valid = 1 → in_ready = 1, out_valid = 0, out_sum = 0, all err_* = 0.
- Approximate result: a = 0x0F, b = 0x01, approx_en = 1, out_ready = 1.
  - Expected: out_sum = 0x00F two cycles after acceptance, err_abs = 1.
  - Same operands with approx_en = 0 → 0x010, err_abs = 0.
- Carry chain: a = 0x88, b = 0x88, approx_en = 1 → out_sum = 0x118, err_abs = 8.
  - Then a = 0xFF, b = 0x01 → 0x0FF, err_abs = 1.
  - Statistics: err_sum = 9, err_max = 8, err_cnt = 2.
- Back-pressure: stream 4 operand pairs with out_ready low for 3 cycles mid-stream → in_ready low the same cycles, no result lost or duplicated, results emitted in order.
- Simultaneous clear: assert err_clr on the cycle a result with err_abs = 8 handshakes → err_sum = err_max = err_cnt = 0 the next cycle.
- Parameter sweep: WIDTH = 16, APPROX_BITS = 0, STAGE_BITS = 5, with 1000 random operand pairs → out_sum equals a+b, latency 4, err_sum = 0.

Source files
------------

// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg: full-adder cells and sizing helpers
// shared by the pipelined approximate ripple-carry adder.
package approx_adder_pkg;

    // Approximate cell: carry-in is deliberately dropped
    function automatic logic [1:0] approx_fa(
        input logic x,
        input logic y,
        input logic z
    );
        return {x & y, (x | y) | (z & 1'b0)};
    endfunction

    // Exact cell, returns {cout, s}
    function automatic logic [1:0] exact_fa(
        input logic x,
        input logic y,
        input logic z
    );
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/approx_rc_stage.sv
// approx_rc_stage: resolves bits [LO..HI] of the ripple chain
// and registers the partial result for the next slice.
module approx_rc_stage
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int LO          = 0,
    parameter int HI          = 3,
    parameter int APPROX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] src_sum,
    input  logic             src_carry,
    input  logic             src_approx,
    output logic             valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             approx
);

    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] sum_n;
    logic             c_n;

    // Ripple through this slice; consumed operand bits are zeroed
    always_comb begin
        a_n   = src_a;
        b_n   = src_b;
        sum_n = src_sum;
        c_n   = src_carry;
        for (int i = LO; i <= HI; i++) begin
            if (src_approx && (i < APPROX_BITS)) begin
                {c_n, sum_n[i]} = approx_fa(src_a[i], src_b[i], c_n);
            end else begin
                {c_n, sum_n[i]} = exact_fa(src_a[i], src_b[i], c_n);
            end
            a_n[i] = 1'b0;
            b_n[i] = 1'b0;
        end
    end

    // Slice register: shifts on every advance, bubbles included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            a      <= '0;
            b      <= '0;
            sum    <= '0;
            carry  <= 1'b0;
            approx <= 1'b0;
        end else if (adv) begin
            valid  <= src_valid;
            a      <= a_n;
            b      <= b_n;
            sum    <= sum_n;
            carry  <= c_n;
            approx <= src_approx;
        end
    end

endmodule

// File: rtl/approx_rc_adder_pipe.sv
// approx_rc_adder_pipe: pipelined approximate ripple-carry adder.
// Optional error monitor: APPROX_ADDER_ERR_MONITOR_EN.
module approx_rc_adder_pipe
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int STAGE_BITS  = 4,
    parameter int ACC_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    input  logic             err_clr,
    output logic [WIDTH:0]   err_abs,
    output logic [ACC_W-1:0] err_sum,
    output logic [WIDTH:0]   err_max,
    output logic [ACC_W-1:0] err_cnt
);

    localparam int STAGES = ceil_div(WIDTH, STAGE_BITS);

    logic             adv;
    logic [STAGES:0]  vld_s;
    logic [STAGES:0]  c_s;
    logic [STAGES:0]  ap_s;
    logic [WIDTH-1:0] a_s   [0:STAGES];
    logic [WIDTH-1:0] b_s   [0:STAGES];
    logic [WIDTH-1:0] sum_s [0:STAGES];
    logic             unused_tail;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    assign vld_s[0] = in_valid;
    assign c_s[0]   = 1'b0;
    assign ap_s[0]  = approx_en;
    assign a_s[0]   = in_a;
    assign b_s[0]   = in_b;
    assign sum_s[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * STAGE_BITS;
        localparam int TOP = (k + 1) * STAGE_BITS;
        localparam int HI  = (TOP < WIDTH ? TOP : WIDTH) - 1;

        approx_rc_stage #(
            .WIDTH       (WIDTH),
            .LO          (LO),
            .HI          (HI),
            .APPROX_BITS (APPROX_BITS)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .adv        (adv),
            .src_valid  (vld_s[k]),
            .src_a      (a_s[k]),
            .src_b      (b_s[k]),
            .src_sum    (sum_s[k]),
            .src_carry  (c_s[k]),
            .src_approx (ap_s[k]),
            .valid      (vld_s[k+1]),
            .a          (a_s[k+1]),
            .b          (b_s[k+1]),
            .sum        (sum_s[k+1]),
            .carry      (c_s[k+1]),
            .approx     (ap_s[k+1])
        );
    end

    assign out_valid = vld_s[STAGES];
    assign out_sum   = {c_s[STAGES], sum_s[STAGES]};

    assign unused_tail = ^{a_s[STAGES], b_s[STAGES], ap_s[STAGES]};

`ifdef APPROX_ADDER_ERR_MONITOR_EN

    logic [WIDTH:0] ref_in;
    logic [WIDTH:0] ref_q [0:STAGES-1];
    logic [ACC_W:0] sum_n;
    logic           hs;

    assign ref_in = {1'b0, in_a} + {1'b0, in_b};
    assign hs     = out_valid & out_ready;
    assign sum_n  = {1'b0, err_sum} + (ACC_W + 1)'(err_abs);

    // Exact reference travels in lockstep with the slices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ref_q[k] <= '0;
            end
        end else if (adv) begin
            ref_q[0] <= ref_in;
            for (int k = 1; k < STAGES; k++) begin
                ref_q[k] <= ref_q[k-1];
            end
        end
    end

    // Approximation can over- or under-estimate, so take magnitude
    always_comb begin
        err_abs = '0;
        if (ref_q[STAGES-1] >= out_sum) begin
            err_abs = ref_q[STAGES-1] - out_sum;
        end else begin
            err_abs = out_sum - ref_q[STAGES-1];
        end
    end

    // Statistics on output handshake; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum <= '0;
            err_max <= '0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err_sum <= '0;
            err_max <= '0;
            err_cnt <= '0;
        end else if (hs) begin
            err_sum <= sum_n[ACC_W] ? '1 : sum_n[ACC_W-1:0];
            if (err_abs > err_max) begin
                err_max <= err_abs;
            end
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`else

    logic unused_clr;

    assign unused_clr = err_clr;
    assign err_abs    = '0;
    assign err_sum    = '0;
    assign err_max    = '0;
    assign err_cnt    = '0;

`endif

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// tb_approx_rc_adder_pipe: directed + random checks of the
// pipelined approximate adder against an arithmetic model.
module tb_approx_rc_adder_pipe;

    localparam int W  = 8;
    localparam int AB = 4;
    localparam int ST = 2;

`ifdef APPROX_ADDER_ERR_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    typedef struct {
        logic [63:0] sum;
        logic [63:0] err;
        int          c0;
        int          s0;
    } ent_t;

    typedef struct {
        logic [63:0] sum;
        int          c0;
    } went_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          approx_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W:0]    out_sum;
    logic          err_clr = 1'b0;
    logic [W:0]    err_abs;
    logic [31:0]   err_sum;
    logic [W:0]    err_max;
    logic [31:0]   err_cnt;

    logic          w_in_valid = 1'b0;
    logic          w_in_ready;
    logic [15:0]   w_a = '0;
    logic [15:0]   w_b = '0;
    logic          w_ap = 1'b0;
    logic          w_out_valid;
    logic          w_out_ready = 1'b1;
    logic [16:0]   w_out_sum;
    logic          w_clr = 1'b0;
    logic [16:0]   w_err_abs;
    logic [31:0]   w_err_sum;
    logic [16:0]   w_err_max;
    logic [31:0]   w_err_cnt;

    approx_rc_adder_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .err_clr   (err_clr),
        .err_abs   (err_abs),
        .err_sum   (err_sum),
        .err_max   (err_max),
        .err_cnt   (err_cnt)
    );

    approx_rc_adder_pipe #(
        .WIDTH       (16),
        .APPROX_BITS (0),
        .STAGE_BITS  (5),
        .ACC_W       (32)
    ) u_w16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_a      (w_a),
        .in_b      (w_b),
        .approx_en (w_ap),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_sum   (w_out_sum),
        .err_clr   (w_clr),
        .err_abs   (w_err_abs),
        .err_sum   (w_err_sum),
        .err_max   (w_err_max),
        .err_cnt   (w_err_cnt)
    );

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     stalls = 0;
    ent_t   q[$];
    went_t  wq[$];
    longint m_sum = 0;
    longint m_max = 0;
    longint m_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Approx LSB field is a plain OR; its top AND feeds the exact part
    function automatic logic [63:0] model(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int ab, input bit ap);
        logic [63:0] mask, lo, hi, cin;
        if (!ap || ab == 0) return a + b;
        mask = (64'd1 << ab) - 64'd1;
        lo   = (a | b) & mask;
        cin  = (a >> (ab - 1)) & (b >> (ab - 1)) & 64'd1;
        hi   = (a >> ab) + (b >> ab) + cin;
        return (hi << ab) | lo;
    endfunction

    task automatic step(output bit acc);
        bit          hs, stall;
        ent_t        e;
        logic [63:0] ex, xs;
        #1;
        acc   = in_valid && in_ready;
        hs    = out_valid && out_ready;
        stall = out_valid && !out_ready;
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (hs) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("out_sum", out_sum, e.sum);
                chk("err_abs", err_abs, e.err);
                chk("latency", cyc - e.c0, ST + stalls - e.s0);
                if (MON) begin
                    m_sum = m_sum + e.err;
                    if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
                    if (e.err > m_max) m_max = e.err;
                    m_cnt++;
                end
            end
        end
        if (stall) stalls++;
        if (acc) begin
            e.sum = model(in_a, in_b, AB, approx_en);
            ex    = in_a + in_b;
            xs    = (ex >= e.sum) ? ex - e.sum : e.sum - ex;
            e.err = MON ? xs : 64'd0;
            e.c0  = cyc;
            e.s0  = stalls;
            q.push_back(e);
        end
        if (err_clr) begin
            m_sum = 0;
            m_max = 0;
            m_cnt = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("err_sum", err_sum, m_sum);
        chk("err_max", err_max, m_max);
        chk("err_cnt", err_cnt, m_cnt);
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b,
                           input bit ap, input bit clr,
                           input logic [8:0] xs, input logic [8:0] xe);
        bit acc;
        int k;
        in_a      = a;
        in_b      = b;
        approx_en = ap;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step(acc);
        chk("dir_accept", acc, 1);
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 10) begin
            step(acc);
            k++;
        end
        chk("dir_latency", k, ST);
        chk("dir_sum", out_sum, xs);
        chk("dir_err", err_abs, MON ? xe : 9'd0);
        err_clr = clr;
        step(acc);
        err_clr = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          sent;
        int          wc;
        logic [7:0]  bpa [4];
        logic [7:0]  bpb [4];
        went_t       we;

        // Reset values with in_valid held high
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_err_abs", err_abs, 0);
        chk("rst_err_sum", err_sum, 0);
        chk("rst_err_max", err_max, 0);
        chk("rst_err_cnt", err_cnt, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Approximate vs exact on the same operands
        run_one(8'h0F, 8'h01, 1'b1, 1'b0, 9'h00F, 9'd1);
        run_one(8'h0F, 8'h01, 1'b0, 1'b0, 9'h010, 9'd0);

        // Clear, then carry-chain cases and statistics
        err_clr = 1'b1;
        step(acc);
        err_clr = 1'b0;
        run_one(8'h88, 8'h88, 1'b1, 1'b0, 9'h118, 9'd8);
        run_one(8'hFF, 8'h01, 1'b1, 1'b0, 9'h0FF, 9'd1);
        chk("stat_sum", err_sum, MON ? 9 : 0);
        chk("stat_max", err_max, MON ? 8 : 0);
        chk("stat_cnt", err_cnt, MON ? 2 : 0);

        // Clear coinciding with a handshake of err_abs = 8
        run_one(8'h88, 8'h88, 1'b1, 1'b1, 9'h118, 9'd8);
        chk("clr_sum", err_sum, 0);
        chk("clr_max", err_max, 0);
        chk("clr_cnt", err_cnt, 0);

        // Back-pressure: 4 operands, out_ready low for 3 cycles
        bpa = '{8'h12, 8'hF0, 8'h7F, 8'hA5};
        bpb = '{8'h34, 8'h0F, 8'h81, 8'h5A};
        sent = 0;
        approx_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            out_ready = !(i >= 3 && i < 6);
            in_valid  = (sent < 4);
            in_a      = bpa[sent % 4];
            in_b      = bpb[sent % 4];
            if (i >= 3 && i < 6) begin
                #1;
                chk("bp_in_ready_low", in_ready, 0);
            end
            step(acc);
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step(acc);
        chk("bp_sent", sent, 4);
        chk("bp_drained", q.size(), 0);

        // Random traffic with random stalls and rare clears
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            approx_en = 1'($urandom);
            err_clr   = ($urandom_range(0, 19) == 0);
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) step(acc);
        chk("rnd_drained", q.size(), 0);

        // Reset with entries in flight: nothing may emerge
        in_a      = 8'h11;
        in_b      = 8'h22;
        in_valid  = 1'b1;
        step(acc);
        step(acc);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sum", out_sum, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        q.delete();
        m_sum = 0;
        m_max = 0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(acc);

        // 16-bit exact sweep, 5-bit slices
        sent = 0;
        wc   = 0;
        while ((sent < 1000 || wq.size() > 0) && wc < 5000) begin
            w_in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            w_a        = 16'($urandom);
            w_b        = 16'($urandom);
            w_ap       = 1'($urandom);
            #1;
            if (w_out_valid) begin
                if (wq.size() == 0) begin
                    chk("w16_spurious", w_out_valid, 0);
                end else begin
                    we = wq.pop_front();
                    chk("w16_sum", w_out_sum, we.sum);
                    chk("w16_latency", wc - we.c0, 4);
                end
            end
            if (w_in_valid && w_in_ready) begin
                we.sum = {48'd0, w_a} + {48'd0, w_b};
                we.c0  = wc;
                wq.push_back(we);
                sent++;
            end
            @(posedge clk);
            wc++;
            @(negedge clk);
        end
        w_in_valid = 1'b0;
        chk("w16_sent", sent, 1000);
        chk("w16_drained", wq.size(), 0);
        chk("w16_err_sum", w_err_sum, 0);
        chk("w16_err_max", w_err_max, 0);
        chk("w16_err_cnt", w_err_cnt, MON ? 1000 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
